// File: rtl/array_sort_ctrl.sv
// -----------------------------------------------------------------------------
// array_sort_ctrl
//
// Purpose:
//   Runs one job per accepted start. It fills a small on-chip array with
//   pseudo-random values in the range 1..100 taken from an 8-bit LFSR, can
//   extend the array to a second length, and sorts the first N = len_b entries
//   with a bubble sort (one compare per cycle). It then streams the sorted
//   entries out over a valid/ready interface.
//
// Ports:
//   clk        : single clock; all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   start      : one-cycle job request, accepted only while idle
//   len_a      : initial fill length (clamped to DEPTH), sampled on start
//   len_b      : resized / effective length (clamped to DEPTH), sampled on start
//   seed       : LFSR seed (0x00 is replaced by 0xA5), sampled on start
//   out_ready  : downstream accepts the current element
//   out_valid  : out_data holds a valid sorted element
//   out_data   : current dump element
//   out_last   : marks the final element of the dump
//   busy       : high whenever the controller is not idle
//   done       : one-cycle pulse after the final element is transferred
//   err        : one-cycle pulse when start is rejected for a zero length
// -----------------------------------------------------------------------------
module array_sort_ctrl #(
    parameter int DEPTH = 16,  // maximum array entries, power of two, 2..16
    parameter int WIDTH = 8    // bits per stored element
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       len_a,
    input  logic [4:0]       len_b,
    input  logic [7:0]       seed,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // Address width for the array; lengths and the pointer are kept 5 bits
    // wide so that a full length of 16 is representable.
    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_L  = 5'(DEPTH);
    localparam logic [7:0] SEED_ALT = 8'hA5;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FILL = 3'd1;
    localparam logic [2:0] S_GROW = 3'd2;
    localparam logic [2:0] S_SORT = 3'd3;
    localparam logic [2:0] S_DUMP = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]       state_q,   state_d;
    logic [4:0]       len_a_q,   len_a_d;
    logic [4:0]       n_q,       n_d;       // effective length N (= len_b)
    logic [4:0]       idx_q,     idx_d;     // write index, compare index j, or dump index
    logic [7:0]       lfsr_q,    lfsr_d;
    logic             swapped_q, swapped_d; // a swap happened in the current pass
    logic             err_q,     err_d;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [4:0]       len_a_clamp;
    logic [4:0]       len_b_clamp;
    logic [4:0]       idx_nxt;
    logic [7:0]       lfsr_step;
    logic [7:0]       lfsr_mod;
    logic [7:0]       elem_val;
    logic [WIDTH-1:0] rd_lo;
    logic [WIDTH-1:0] rd_hi;
    logic             wr_en;
    logic             swap_now;

    // -------------------------------------------------------------------------
    // Datapath helpers
    // -------------------------------------------------------------------------
    assign len_a_clamp = (len_a > DEPTH_L) ? DEPTH_L : len_a;
    assign len_b_clamp = (len_b > DEPTH_L) ? DEPTH_L : len_b;

    assign idx_nxt   = idx_q + 5'd1;
    assign lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign lfsr_mod  = lfsr_q % 8'd100;
    assign elem_val  = lfsr_mod + 8'd1;

    // Two read ports: mem[idx] serves both the dump and the left side of the
    // bubble compare, mem[idx+1] the right side.
    assign rd_lo = mem_q[idx_q[AW-1:0]];
    assign rd_hi = mem_q[idx_nxt[AW-1:0]];

    assign wr_en    = (state_q == S_FILL) || (state_q == S_GROW);
    assign swap_now = (state_q == S_SORT) && (rd_lo > rd_hi);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here receives a default first, so no path
    // leaves a value unassigned and no latch can be inferred.
    always_comb begin
        state_d   = state_q;
        len_a_d   = len_a_q;
        n_d       = n_q;
        idx_d     = idx_q;
        lfsr_d    = lfsr_q;
        swapped_d = swapped_q;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((len_a_clamp == 5'd0) || (len_b_clamp == 5'd0)) begin
                        err_d = 1'b1;
                    end else begin
                        len_a_d   = len_a_clamp;
                        n_d       = len_b_clamp;
                        lfsr_d    = (seed == 8'h00) ? SEED_ALT : seed;
                        idx_d     = 5'd0;
                        swapped_d = 1'b0;
                        state_d   = S_FILL;
                    end
                end
            end

            S_FILL: begin
                lfsr_d = lfsr_step;
                if (idx_q == len_a_q - 5'd1) begin
                    if (n_q > len_a_q) begin
                        // GROW carries on from index len_a with the same LFSR run.
                        idx_d   = idx_nxt;
                        state_d = S_GROW;
                    end else begin
                        idx_d   = 5'd0;
                        state_d = (n_q == 5'd1) ? S_DUMP : S_SORT;
                    end
                end else begin
                    idx_d = idx_nxt;
                end
            end

            S_GROW: begin
                lfsr_d = lfsr_step;
                if (idx_q == n_q - 5'd1) begin
                    // len_b > len_a >= 1 here, so N >= 2 and a sort is needed.
                    idx_d   = 5'd0;
                    state_d = S_SORT;
                end else begin
                    idx_d = idx_nxt;
                end
            end

            S_SORT: begin
                if (idx_q == n_q - 5'd2) begin
                    // End of a pass: a clean pass means the array is ordered.
                    idx_d     = 5'd0;
                    swapped_d = 1'b0;
                    if (!(swapped_q || swap_now)) begin
                        state_d = S_DUMP;
                    end
                end else begin
                    idx_d     = idx_nxt;
                    swapped_d = swapped_q || swap_now;
                end
            end

            S_DUMP: begin
                if (out_ready) begin
                    if (idx_q == n_q - 5'd1) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_nxt;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of all others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            len_a_q   <= 5'd0;
            n_q       <= 5'd0;
            idx_q     <= 5'd0;
            lfsr_q    <= SEED_ALT;
            swapped_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_a_q   <= len_a_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            lfsr_q    <= lfsr_d;
            swapped_q <= swapped_d;
            err_q     <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Array storage
    // -------------------------------------------------------------------------
    // NOTE: the array has no reset; every entry that is read is written by
    // FILL/GROW of the same job first, and leaving it unreset lets it map
    // onto plain storage.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[idx_q[AW-1:0]] <= WIDTH'(elem_val);
        end else if (swap_now) begin
            mem_q[idx_q[AW-1:0]]   <= rd_hi;
            mem_q[idx_nxt[AW-1:0]] <= rd_lo;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // The dump pointer only moves on a transfer, so out_data and out_last
    // stay stable while the consumer stalls.
    assign out_valid = (state_q == S_DUMP);
    assign out_data  = out_valid ? rd_lo : '0;
    assign out_last  = out_valid && (idx_q == n_q - 5'd1);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;

endmodule
